buzzer_alert_sched: RTL and testbench
=====================================

Name: buzzer_alert_sched

Overview:
Proximity-alert scheduler that owns the buzzer. It takes echo-duration measurements from the ultrasonic front end, classifies each one into a distance zone, and sequences the buzzer with a zone-dependent beep cadence and audible tone. Cadence runs from intermittent through fast to continuous. The output pin is active-low: 1 means silent.

Parameters:
TONE_HALF, 3000, tone half-period in clk cycles (2 kHz at 12 MHz)
NEAR_TH, 1750, duration below this selects zone 3 (continuous)
MID_TH, 3500, duration below this selects zone 2 (fast beep)
FAR_TH, 7000, duration below this selects zone 1 (slow beep)
ON_CYC, 1200000, beep-on phase length in clk cycles
OFF_MID, 1200000, beep-off phase length in zone 2
OFF_FAR, 4800000, beep-off phase length in zone 1
STALE_CYC, 24000000, cycles without a measurement before the zone is forced to 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
enable  input  1  alert enable; low silences the block immediately
duration  input  32  echo duration, in the same units as the thresholds
dur_valid  input  1  one-cycle strobe; duration is valid in this cycle
buzzer_out  output  1  buzzer drive, active-low (1 = silent)
zone  output  2  current registered zone, 0 = none, 3 = nearest
active  output  1  high while the FSM is in BEEP_ON, BEEP_OFF or CONT

Behaviour:
- Reset is sampled on the clk edge while rst=0. Reset values:
  - buzzer_out=1, zone=0, active=0.
  - FSM=IDLE; phase, tone and stale counters=0.
  - Reset mid-beep silences the buzzer on the same edge.
- Classification on dur_valid=1, using strict less-than:
  - duration<NEAR_TH gives 3; else <MID_TH gives 2; else <FAR_TH gives 1; else 0.
  - The zone register updates on the edge that samples dur_valid.
  - A value equal to a threshold falls in the farther zone.
- Stale timer:
  - Reloads to 0 on each dur_valid and increments otherwise, saturating.
  - On reaching STALE_CYC-1 without dur_valid, zone is set to 0.
  - If dur_valid and expiry fall in the same cycle, dur_valid wins.
- FSM states: IDLE, BEEP_ON, BEEP_OFF, CONT.
  - IDLE: if enable and zone=3, go to CONT; if enable and zone is 1 or 2, go to BEEP_ON; otherwise stay.
  - BEEP_ON: lasts exactly ON_CYC cycles, then goes to BEEP_OFF.
  - BEEP_OFF: lasts OFF_MID cycles if zone=2 at phase entry, OFF_FAR if zone=1 at phase entry.
  - At the end of BEEP_OFF, re-evaluate zone: 3 goes to CONT, 1 or 2 goes to BEEP_ON, 0 goes to IDLE.
  - Zone changes during BEEP_ON or BEEP_OFF take effect only at the phase boundary. Exception: a change to zone 3 moves to CONT on the next cycle.
  - If BEEP_OFF is entered with zone 0 (zone dropped during BEEP_ON), it uses OFF_FAR and then goes to IDLE.
  - CONT: re-evaluated every cycle; zone 1 or 2 goes to BEEP_OFF, zone 0 goes to IDLE.
  - enable=0 forces IDLE on the next edge from any state.
  - Phase counter resets to 0 on every state entry.
- Tone generation:
  - In BEEP_ON and CONT, the tone counter runs 0..TONE_HALF-1 and toggles the tone bit on wrap.
  - buzzer_out = ~tone, registered.
  - On entry to a sounding state, tone=1, so buzzer_out=0 on the first cycle in that state. Output is low for TONE_HALF cycles, then high for TONE_HALF cycles, repeating.
  - In IDLE and BEEP_OFF, buzzer_out=1 and the tone counter is held at 0.
- Latency from dur_valid to the first buzzer_out=0 (from IDLE, enable=1):
  - Edge 1: zone register updates.
  - Edge 2: FSM enters a sounding state; buzzer_out goes low.
- active is registered and mirrors the state: 1 in every state except IDLE.
- All arithmetic is unsigned 32-bit. The phase counter is 32-bit.

Test Plan:
Common overrides: TONE_HALF=4, NEAR_TH=10, MID_TH=20, FAR_TH=40, ON_CYC=16, OFF_MID=16, OFF_FAR=48, STALE_CYC=400.
- Reset: hold rst=0 for 5 cycles with dur_valid pulsing duration=5 -> buzzer_out=1, zone=0, active=0 throughout. Release -> still silent until the next dur_valid.
- Zone 2 cadence: enable=1; pulse duration=15 every 100 cycles -> zone=2. buzzer_out toggles every 4 cycles (starting low) for 16 cycles, then holds 1 for 16 cycles, repeating. First low arrives 2 edges after the strobe.
- Thresholds: duration=10 -> zone 2; duration=9 -> zone 3 with a continuous 4/4 tone; duration=40 -> zone 0, so the FSM returns to IDLE from CONT next cycle, or at the BEEP_OFF end from a beep state.
- Preemption: in zone 1 BEEP_OFF, strobe duration=3 -> CONT on the cycle after the zone update, with buzzer_out=0 on entry.
- Stale: in zone 2, stop strobing -> 400 cycles after the last strobe zone=0. The FSM finishes its current phase, then goes to IDLE with buzzer_out=1. A strobe on the expiry cycle keeps zone at the new value.
- Enable and reset mid-operation: drop enable mid-BEEP_ON -> IDLE and buzzer_out=1 on the next edge; re-enable -> BEEP_ON with the phase counter restarted. Assert rst=0 mid-CONT -> all outputs at reset values on that edge.

Source files
------------

// File: rtl/buzzer_alert_sched_if.sv
// ============================================================================
// Module      : buzzer_alert_sched_if
// Description : Measurement-in / buzzer-out bundle for the proximity alert
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface buzzer_alert_sched_if;
    logic        enable;
    logic [31:0] duration;
    logic        dur_valid;
    logic        buzzer_out;
    logic [1:0]  zone;
    logic        active;

    modport master (
        output enable,
        output duration,
        output dur_valid,
        input  buzzer_out,
        input  zone,
        input  active
    );

    modport slave (
        input  enable,
        input  duration,
        input  dur_valid,
        output buzzer_out,
        output zone,
        output active
    );
endinterface

`default_nettype wire

// File: rtl/buzzer_alert_sched.sv
// ============================================================================
// Module      : buzzer_alert_sched
// Description : Classifies echo durations into distance zones and drives an
//               active-low buzzer with a zone-dependent beep cadence and tone.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buzzer_alert_sched #(
    parameter int unsigned TONE_HALF = 3000,
    parameter int unsigned NEAR_TH   = 1750,
    parameter int unsigned MID_TH    = 3500,
    parameter int unsigned FAR_TH    = 7000,
    parameter int unsigned ON_CYC    = 1200000,
    parameter int unsigned OFF_MID   = 1200000,
    parameter int unsigned OFF_FAR   = 4800000,
    parameter int unsigned STALE_CYC = 24000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    buzzer_alert_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        CONT     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] phase;
    logic [31:0] phase_nxt;
    logic [31:0] off_len;
    logic [31:0] off_len_nxt;
    logic [31:0] tone_cnt;
    logic [31:0] tone_cnt_nxt;
    logic        tone;
    logic        tone_nxt;
    logic [31:0] stale;
    logic [1:0]  zone_q;
    logic [1:0]  zone_class;
    logic        buzzer_q;
    logic        active_q;
    logic        entering;
    logic        sounding_nxt;

    assign bus.zone       = zone_q;
    assign bus.buzzer_out = buzzer_q;
    assign bus.active     = active_q;

    always_comb begin
        zone_class = 2'd0;
        if (bus.duration < NEAR_TH)
            zone_class = 2'd3;
        else if (bus.duration < MID_TH)
            zone_class = 2'd2;
        else if (bus.duration < FAR_TH)
            zone_class = 2'd1;
    end

    // A fresh measurement always beats the staleness expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            zone_q <= 2'd0;
            stale  <= 32'd0;
        end else if (bus.dur_valid) begin
            zone_q <= zone_class;
            stale  <= 32'd0;
        end else if (stale == STALE_CYC - 32'd1) begin
            zone_q <= 2'd0;
        end else begin
            stale  <= stale + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            phase    <= 32'd0;
            off_len  <= OFF_FAR;
            tone_cnt <= 32'd0;
            tone     <= 1'b0;
            buzzer_q <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            off_len  <= off_len_nxt;
            tone_cnt <= tone_cnt_nxt;
            tone     <= tone_nxt;
            buzzer_q <= ~tone_nxt;
            active_q <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (zone_q == 2'd3)
                    state_nxt = CONT;
                else if (zone_q != 2'd0)
                    state_nxt = BEEP_ON;
            end
            BEEP_ON: begin
                if (zone_q == 2'd3)
                    state_nxt = CONT;
                else if (phase == ON_CYC - 32'd1)
                    state_nxt = BEEP_OFF;
            end
            BEEP_OFF: begin
                if (zone_q == 2'd3)
                    state_nxt = CONT;
                else if (phase == off_len - 32'd1)
                    state_nxt = (zone_q != 2'd0) ? BEEP_ON : IDLE;
            end
            CONT: begin
                if (zone_q == 2'd1 || zone_q == 2'd2)
                    state_nxt = BEEP_OFF;
                else if (zone_q == 2'd0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.enable)
            state_nxt = IDLE;

        entering     = (state_nxt != state);
        sounding_nxt = (state_nxt == BEEP_ON) || (state_nxt == CONT);

        phase_nxt = 32'd0;
        if (!entering && (state == BEEP_ON || state == BEEP_OFF))
            phase_nxt = phase + 32'd1;

        // Off length is frozen by the zone seen at the moment BEEP_OFF is entered.
        off_len_nxt = off_len;
        if (entering && state_nxt == BEEP_OFF)
            off_len_nxt = (zone_q == 2'd2) ? OFF_MID : OFF_FAR;

        tone_cnt_nxt = 32'd0;
        tone_nxt     = 1'b0;
        if (sounding_nxt) begin
            if (entering) begin
                tone_nxt = 1'b1;
            end else if (tone_cnt == TONE_HALF - 32'd1) begin
                tone_nxt = ~tone;
            end else begin
                tone_cnt_nxt = tone_cnt + 32'd1;
                tone_nxt     = tone;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_buzzer_alert_sched.sv
// ============================================================================
// Module      : tb_buzzer_alert_sched
// Description : Randomised and directed bench for buzzer_alert_sched against
//               an elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buzzer_alert_sched;

    localparam int TONE_HALF = 4;
    localparam int NEAR_TH   = 10;
    localparam int MID_TH    = 20;
    localparam int FAR_TH    = 40;
    localparam int ON_CYC    = 16;
    localparam int OFF_MID   = 16;
    localparam int OFF_FAR   = 48;
    localparam int STALE_CYC = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buzzer_alert_sched_if bus ();

    buzzer_alert_sched #(
        .TONE_HALF(TONE_HALF), .NEAR_TH(NEAR_TH), .MID_TH(MID_TH), .FAR_TH(FAR_TH),
        .ON_CYC(ON_CYC), .OFF_MID(OFF_MID), .OFF_FAR(OFF_FAR), .STALE_CYC(STALE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_strobe = 0;
    int          m_mode = 0;   // 0 idle, 1 beep on, 2 beep off, 3 continuous
    int          m_t = 0;      // cycles elapsed in the current mode
    int          m_len = OFF_FAR;
    logic [1:0]  m_zone = 2'd0;
    logic        m_buz = 1'b1;
    logic        m_act = 1'b0;

    function automatic logic [1:0] classify(input int unsigned d);
        if (d < NEAR_TH) return 2'd3;
        if (d < MID_TH)  return 2'd2;
        if (d < FAR_TH)  return 2'd1;
        return 2'd0;
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        int nm;
        cyc++;
        if (!rst) begin
            m_mode = 0; m_t = 0; m_zone = 2'd0; last_strobe = cyc;
        end else begin
            nm = m_mode;
            case (m_mode)
                0: if (m_zone == 3) nm = 3; else if (m_zone != 0) nm = 1;
                1: if (m_zone == 3) nm = 3; else if (m_t + 1 == ON_CYC) nm = 2;
                2: if (m_zone == 3) nm = 3; else if (m_t + 1 == m_len) nm = (m_zone != 0) ? 1 : 0;
                default: if (m_zone == 1 || m_zone == 2) nm = 2; else if (m_zone == 0) nm = 0;
            endcase
            if (!bus.enable) nm = 0;
            if (nm == 2 && m_mode != 2) m_len = (m_zone == 2) ? OFF_MID : OFF_FAR;
            m_t    = (nm == m_mode) ? m_t + 1 : 0;
            m_mode = nm;
            if (bus.dur_valid) begin
                m_zone = classify(bus.duration);
                last_strobe = cyc;
            end else if (cyc - last_strobe >= STALE_CYC) begin
                m_zone = 2'd0;
            end
        end
        m_act = (m_mode != 0);
        m_buz = (m_mode == 1 || m_mode == 3) ? ((m_t / TONE_HALF) % 2 != 0) : 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.dur_valid = 1'b1; bus.duration = 32'd5;
            tick();
            checks++; if (bus.buzzer_out !== 1'b1) begin errors++; $display("FAIL reset_buzzer cyc=%0d got=%b exp=1", cyc, bus.buzzer_out); end
            checks++; if (bus.zone !== 2'd0) begin errors++; $display("FAIL reset_zone cyc=%0d got=%0d exp=0", cyc, bus.zone); end
            checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active cyc=%0d got=%b exp=0", cyc, bus.active); end
        end
        bus.dur_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.buzzer_out !== 1'b1) begin errors++; $display("FAIL post_reset_buzzer cyc=%0d got=%b exp=1", cyc, bus.buzzer_out); end
            checks++; if (bus.zone !== 2'd0) begin errors++; $display("FAIL post_reset_zone cyc=%0d got=%0d exp=0", cyc, bus.zone); end
            checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL post_reset_active cyc=%0d got=%b exp=0", cyc, bus.active); end
        end
    endtask

    task automatic test_zone2_cadence();
        for (int s = 0; s < 3; s++) begin
            bus.dur_valid = 1'b1; bus.duration = 32'd15;
            for (int i = 0; i < 100; i++) begin
                tick();
                bus.dur_valid = 1'b0;
                checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL cadence_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
                checks++; if (bus.zone !== m_zone) begin errors++; $display("FAIL cadence_zone cyc=%0d got=%0d exp=%0d", cyc, bus.zone, m_zone); end
                checks++; if (bus.active !== m_act) begin errors++; $display("FAIL cadence_active cyc=%0d got=%b exp=%b", cyc, bus.active, m_act); end
            end
        end
    endtask

    task automatic test_thresholds();
        int unsigned vals [9] = '{10, 9, 40, 20, 19, 39, 40, 30, 0};
        foreach (vals[k]) begin
            bus.dur_valid = 1'b1; bus.duration = vals[k];
            for (int i = 0; i < 80; i++) begin
                tick();
                bus.dur_valid = 1'b0;
                checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL thresh_buzzer dur=%0d cyc=%0d got=%b exp=%b", vals[k], cyc, bus.buzzer_out, m_buz); end
                checks++; if (bus.zone !== m_zone) begin errors++; $display("FAIL thresh_zone dur=%0d cyc=%0d got=%0d exp=%0d", vals[k], cyc, bus.zone, m_zone); end
                checks++; if (bus.active !== m_act) begin errors++; $display("FAIL thresh_active dur=%0d cyc=%0d got=%b exp=%b", vals[k], cyc, bus.active, m_act); end
            end
        end
    endtask

    task automatic test_preemption();
        bit found = 0;
        bus.dur_valid = 1'b1; bus.duration = 32'd30;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            bus.dur_valid = 1'b0;
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL preempt_wait_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
            if (m_mode == 2 && m_t == 5) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL preempt_reach_off got=timeout exp=beep_off"); end
        bus.dur_valid = 1'b1; bus.duration = 32'd3;
        tick();
        bus.dur_valid = 1'b0;
        checks++; if (bus.zone !== 2'd3) begin errors++; $display("FAIL preempt_zone got=%0d exp=3", bus.zone); end
        checks++; if (bus.buzzer_out !== 1'b1) begin errors++; $display("FAIL preempt_still_off got=%b exp=1", bus.buzzer_out); end
        tick();
        checks++; if (bus.buzzer_out !== 1'b0) begin errors++; $display("FAIL preempt_cont_entry got=%b exp=0", bus.buzzer_out); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL preempt_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
            checks++; if (bus.active !== m_act) begin errors++; $display("FAIL preempt_active cyc=%0d got=%b exp=%b", cyc, bus.active, m_act); end
        end
    endtask

    task automatic test_stale();
        bus.dur_valid = 1'b1; bus.duration = 32'd15;
        for (int i = 0; i < 500; i++) begin
            tick();
            bus.dur_valid = 1'b0;
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL stale_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
            checks++; if (bus.zone !== m_zone) begin errors++; $display("FAIL stale_zone cyc=%0d got=%0d exp=%0d", cyc, bus.zone, m_zone); end
            checks++; if (bus.active !== m_act) begin errors++; $display("FAIL stale_active cyc=%0d got=%b exp=%b", cyc, bus.active, m_act); end
        end
        checks++; if (bus.zone !== 2'd0 || bus.buzzer_out !== 1'b1) begin errors++; $display("FAIL stale_final zone=%0d buzzer=%b exp zone=0 buzzer=1", bus.zone, bus.buzzer_out); end
        bus.dur_valid = 1'b1; bus.duration = 32'd15;
        for (int i = 0; i < 400; i++) begin
            tick();
            bus.dur_valid = 1'b0;
            checks++; if (bus.zone !== m_zone) begin errors++; $display("FAIL stale_race_zone cyc=%0d got=%0d exp=%0d", cyc, bus.zone, m_zone); end
            if (i == 398) begin bus.dur_valid = 1'b1; bus.duration = 32'd25; end
        end
        checks++; if (bus.zone !== 2'd1) begin errors++; $display("FAIL stale_strobe_wins got=%0d exp=1", bus.zone); end
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL stale_after_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
        end
    endtask

    task automatic test_enable_reset();
        bit found = 0;
        bus.dur_valid = 1'b1; bus.duration = 32'd15;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            bus.dur_valid = 1'b0;
            if (m_mode == 1 && m_t == 5) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL enable_reach_on got=timeout exp=beep_on"); end
        bus.enable = 1'b0;
        tick();
        checks++; if (bus.buzzer_out !== 1'b1) begin errors++; $display("FAIL disable_buzzer got=%b exp=1", bus.buzzer_out); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL disable_active got=%b exp=0", bus.active); end
        for (int i = 0; i < 5; i++) tick();
        bus.enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL reenable_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
            checks++; if (bus.active !== m_act) begin errors++; $display("FAIL reenable_active cyc=%0d got=%b exp=%b", cyc, bus.active, m_act); end
        end
        found = 0;
        bus.dur_valid = 1'b1; bus.duration = 32'd3;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            bus.dur_valid = 1'b0;
            if (m_mode == 3 && m_t == 6) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL reset_reach_cont got=timeout exp=cont"); end
        rst = 1'b0;
        tick();
        checks++; if (bus.buzzer_out !== 1'b1 || bus.zone !== 2'd0 || bus.active !== 1'b0) begin
            errors++; $display("FAIL midcont_reset buzzer=%b zone=%0d active=%b exp 1/0/0", bus.buzzer_out, bus.zone, bus.active);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL after_reset_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
        end
    endtask

    task automatic test_random();
        bit quiet = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) quiet = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
            bus.dur_valid = (!quiet && $urandom_range(0, 24) == 0);
            bus.duration  = $urandom_range(0, 50);
            tick();
            checks++; if (bus.buzzer_out !== m_buz) begin errors++; $display("FAIL rand_buzzer cyc=%0d got=%b exp=%b", cyc, bus.buzzer_out, m_buz); end
            checks++; if (bus.zone !== m_zone) begin errors++; $display("FAIL rand_zone cyc=%0d got=%0d exp=%0d", cyc, bus.zone, m_zone); end
            checks++; if (bus.active !== m_act) begin errors++; $display("FAIL rand_active cyc=%0d got=%b exp=%b", cyc, bus.active, m_act); end
        end
        bus.dur_valid = 1'b0;
        bus.enable = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus.enable = 1'b0;
        bus.dur_valid = 1'b0;
        bus.duration = 32'd0;
        tick();
        test_reset();
        test_zone2_cadence();
        test_thresholds();
        test_preemption();
        test_stale();
        test_enable_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
